npu_layer_scheduler: RTL and testbench
======================================

# npu_layer_scheduler

Top-level layer sequencer for the NPU. It steps the ping-pong SRAM datapath through a programmable number of network layers. For each layer it requests a weight load from the host, clears the accumulator, and launches one compute pass on the datapath sequencer. It waits for that pass to complete, then swaps the input/output SRAM banks. It sits between the host/loader interface and the per-pass datapath controller.

## Interface
- `width`, 16 — vector length / SRAM depth per pass; sets the watchdog limit
- `MAX_LAYERS`, 8 — maximum layers per run; `LW = $clog2(MAX_LAYERS)+1`
- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — reset, synchronous and active-low
- `start` in 1 — request to begin a run; sampled only in IDLE
- `num_layers` in LW — layer count, latched on accepted `start`
- `ld_req` out 1 — weight-load request for current layer; held until `ld_ack`
- `ld_ack` in 1 — host finished loading weights; sampled only in LOAD
- `acc_clr` out 1 — one-cycle accumulator clear before each pass
- `pass_start` out 1 — one-cycle pulse launching the datapath pass
- `pass_done` in 1 — pass-complete pulse from the datapath; sampled only in WAIT
- `bank_sel` out 1 — 0: SRAM1 holds layer input, 1: SRAM2 holds layer input
- `layer_idx` out LW — index of the layer in progress, 0-based
- `busy` out 1 — high from accepted `start` through the DONE cycle, inclusive
- `done` out 1 — one-cycle pulse when the run completes normally
- `err` out 1 — sticky error flag

## Operation
- Reset (`rst`=0 at posedge): state=IDLE; all outputs 0, including `layer_idx`, `bank_sel`, `err` and the latched count.
- States: IDLE, LOAD, CLEAR, RUN, WAIT, SWAP, DONE.
- IDLE, on `start`=1:
  - `num_layers` > MAX_LAYERS: set `err`, stay IDLE, `busy` stays 0.
  - `num_layers` = 0: go to DONE; `err` cleared.
  - Otherwise: latch count, `layer_idx`←0, `bank_sel`←0, `err`←0, go to LOAD.
- LOAD: `ld_req`=1. On `ld_ack`=1 go to CLEAR.
- CLEAR: `acc_clr`=1 for this single cycle, then go to RUN.
- RUN: `pass_start`=1 for this single cycle, then go to WAIT.
- WAIT: on `pass_done`=1 go to SWAP.
- SWAP: toggle `bank_sel`.
  - If `layer_idx` = count−1, go to DONE.
  - Otherwise increment `layer_idx` and go to LOAD.
- DONE: `done`=1, `busy`=1 for this single cycle, then go to IDLE.
- Out-of-state inputs:
  - `start` outside IDLE is ignored.
  - `ld_ack` outside LOAD is ignored.
  - `pass_done` outside WAIT, including the RUN cycle, is ignored.
- `layer_idx` and `bank_sel` hold their final values in IDLE until the next accepted `start`.
- Reset asserted in any state aborts the run on that posedge. No `done` pulse is issued, and all outputs return to reset values.

## Timing
- All outputs are registered, driven by the state register.
- `start` at posedge t: `busy` and `ld_req` high from t+1.
- `ld_ack` at t: `ld_req` low and `acc_clr` high at t+1; `pass_start` at t+2.
- `pass_done` at t: SWAP at t+1, where `bank_sel` and `layer_idx` update and are visible at t+2. At t+2 either `ld_req` goes high or `done` pulses.
- Minimum per-layer overhead beyond the load and pass durations: 4 cycles (LOAD-exit, CLEAR, RUN, SWAP).
- Back-to-back runs:
  - A `start` on the DONE cycle is ignored.
  - The earliest accepted `start` is the first IDLE cycle, one cycle after `done`.

## Configuration
- `NPU_LAYER_SCHED_WATCHDOG_EN` defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - If 4*`width` cycles elapse without `pass_done`: set `err`, go directly to IDLE, `busy`←0, no `done` pulse.
  - A `pass_done` on the limit cycle wins over the timeout.
- Undefined: no counter is built, and WAIT waits indefinitely. `err` is set only by an out-of-range `num_layers`.

## Test plan
- Reset mid-WAIT: `rst`=0 for 1 cycle. Next cycle shows state IDLE with all outputs 0, and no `done` pulse.
- `num_layers`=3 run, `ld_ack` 2 cycles after each `ld_req`, `pass_done` 5 cycles after each `pass_start`:
  - Exactly 3 each of `ld_req` assertions, `acc_clr` pulses and `pass_start` pulses.
  - `layer_idx` takes values 0,1,2; `bank_sel` ends at 1.
  - One `done` pulse, two cycles after the third `pass_done`.
- `num_layers`=0: `done` pulses at t+1 with `busy` high for that single cycle, and no `ld_req`. `num_layers`=9 with MAX_LAYERS=8: `err`=1, `busy` stays 0.
- `start`, `ld_ack` and `pass_done` pulsed in wrong states (e.g. `pass_done` in LOAD, `start` in WAIT): state and outputs unchanged.
- Watchdog on, `width`=16, no `pass_done`: `err`=1 and state IDLE exactly 64 cycles after WAIT entry. `pass_done` on cycle 64 instead: SWAP is entered and `err`=0.

Source files
------------

// File: rtl/npu_layer_scheduler_if.sv
// Handshake bundle between the host/loader, the layer scheduler and the datapath sequencer.
// master: host/loader + datapath side, slave: the scheduler.
interface npu_layer_scheduler_if #(
  parameter int LW = 4
);
  logic          start;
  logic [LW-1:0] num_layers;
  logic          ld_req;
  logic          ld_ack;
  logic          acc_clr;
  logic          pass_start;
  logic          pass_done;
  logic          bank_sel;
  logic [LW-1:0] layer_idx;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, num_layers, ld_ack, pass_done,
    input  ld_req, acc_clr, pass_start, bank_sel, layer_idx, busy, done, err
  );

  modport slave (
    input  start, num_layers, ld_ack, pass_done,
    output ld_req, acc_clr, pass_start, bank_sel, layer_idx, busy, done, err
  );
endinterface

// File: rtl/npu_layer_scheduler.sv
// NPU layer sequencer: load weights, clear accumulator, run one pass, swap ping-pong banks, per layer.
// Optional WAIT watchdog (4*width cycles) is built when NPU_LAYER_SCHED_WATCHDOG_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; layer_idx/bank_sel hold last run's values
// S_LOAD  | ld_req high until the host acknowledges the weight load
// S_CLEAR | acc_clr pulse
// S_RUN   | pass_start pulse
// S_WAIT  | waiting for pass_done (optionally bounded by the watchdog)
// S_SWAP  | toggle bank_sel, advance layer or finish
// S_DONE  | done pulse, last busy cycle
module npu_layer_scheduler #(
  parameter int width      = 16,
  parameter int MAX_LAYERS = 8,
  parameter int LW         = $clog2(MAX_LAYERS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  npu_layer_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_SWAP,
    S_DONE
  } state_t;

  if (width < 1 || MAX_LAYERS < 1) begin : g_bad_params
    $error("npu_layer_scheduler: width and MAX_LAYERS must be at least 1");
  end

  state_t        state;
  logic [LW-1:0] count;
  logic [LW-1:0] layer_idx;
  logic          bank_sel;
  logic          ld_req;
  logic          acc_clr;
  logic          pass_start;
  logic          busy;
  logic          done;
  logic          err;

`ifdef NPU_LAYER_SCHED_WATCHDOG_EN
  localparam int WD_LIMIT = 4 * width;
  localparam int WDW      = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
  logic [WDW-1:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      count      <= '0;
      layer_idx  <= '0;
      bank_sel   <= 1'b0;
      ld_req     <= 1'b0;
      acc_clr    <= 1'b0;
      pass_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef NPU_LAYER_SCHED_WATCHDOG_EN
      wd_cnt     <= '0;
`endif
    end else begin
      acc_clr    <= 1'b0;
      pass_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_layers > LW'(MAX_LAYERS)) begin
              err <= 1'b1;
            end else if (bus.num_layers == '0) begin
              err   <= 1'b0;
              busy  <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              count     <= bus.num_layers;
              layer_idx <= '0;
              bank_sel  <= 1'b0;
              err       <= 1'b0;
              busy      <= 1'b1;
              ld_req    <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.ld_ack) begin
            ld_req  <= 1'b0;
            acc_clr <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pass_start <= 1'b1;
          state      <= S_RUN;
        end
        S_RUN: begin
          // pass_done during RUN is deliberately not looked at
`ifdef NPU_LAYER_SCHED_WATCHDOG_EN
          wd_cnt <= WDW'(WD_LIMIT - 1);
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.pass_done) begin
            state <= S_SWAP;
          end
`ifdef NPU_LAYER_SCHED_WATCHDOG_EN
          else if (wd_cnt == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - WDW'(1);
          end
`endif
        end
        S_SWAP: begin
          bank_sel <= ~bank_sel;
          if (layer_idx == count - LW'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            layer_idx <= layer_idx + LW'(1);
            ld_req    <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ld_req <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ld_req     = ld_req;
  assign bus.acc_clr    = acc_clr;
  assign bus.pass_start = pass_start;
  assign bus.bank_sel   = bank_sel;
  assign bus.layer_idx  = layer_idx;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;

endmodule

// File: tb/tb_npu_layer_scheduler.sv
// Randomized bench for npu_layer_scheduler: drives host/datapath handshakes with random delays
// and spurious out-of-state pulses, checking against per-run expectations derived from the layer count.
`timescale 1ns/1ps
module tb_npu_layer_scheduler;
  localparam int WIDTH      = 16;
  localparam int MAX_LAYERS = 8;
  localparam int LW         = $clog2(MAX_LAYERS) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  npu_layer_scheduler_if #(.LW(LW)) bus ();

  npu_layer_scheduler #(.width(WIDTH), .MAX_LAYERS(MAX_LAYERS), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // pulse counters and the layer index seen at each ld_req rise
  int   cnt_ld = 0, cnt_clr = 0, cnt_ps = 0, cnt_done = 0;
  logic ld_prev = 1'b0;
  int   idx_q[$];

  always @(negedge clk) begin
    if (bus.ld_req && !ld_prev) begin
      cnt_ld <= cnt_ld + 1;
      idx_q.push_back(int'(bus.layer_idx));
    end
    if (bus.acc_clr)    cnt_clr  <= cnt_clr + 1;
    if (bus.pass_start) cnt_ps   <= cnt_ps + 1;
    if (bus.done)       cnt_done <= cnt_done + 1;
    ld_prev <= bus.ld_req;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    bus.start      = 1'b1;
    bus.num_layers = LW'(n);
    tick();
    bus.start      = 1'b0;
    bus.num_layers = LW'($urandom);
  endtask

  // From LOAD with ld_req visible: spurious pulses, ld_ack, then CLEAR and RUN; returns in first WAIT cycle.
  task automatic load_and_launch(input int idx, input int ack_lo, input int ack_hi);
    int d;
    d = $urandom_range(ack_hi, ack_lo);
    repeat (d) begin
      bus.pass_done  = 1'($urandom_range(1, 0));
      bus.start      = 1'($urandom_range(1, 0));
      bus.num_layers = LW'($urandom);
      tick();
      check_val("load_hold_req", bus.ld_req, 1);
      check_val("load_hold_idx", bus.layer_idx, 32'(idx));
      check_val("load_no_clr", bus.acc_clr, 0);
    end
    bus.pass_done = 1'b0;
    bus.start     = 1'b0;
    bus.ld_ack    = 1'b1;
    tick();
    bus.ld_ack    = 1'b0;
    check_val("clear_req_low", bus.ld_req, 0);
    check_val("clear_pulse", bus.acc_clr, 1);
    bus.pass_done = 1'($urandom_range(1, 0));
    tick();
    check_val("run_pulse", bus.pass_start, 1);
    check_val("run_clr_low", bus.acc_clr, 0);
    bus.pass_done = 1'($urandom_range(1, 0));
    bus.ld_ack    = 1'($urandom_range(1, 0));
    tick();
    bus.pass_done = 1'b0;
    bus.ld_ack    = 1'b0;
    check_val("wait_ps_low", bus.pass_start, 0);
    check_val("wait_busy", bus.busy, 1);
  endtask

  // From first WAIT cycle: spurious pulses, pass_done, SWAP; returns one cycle after SWAP.
  task automatic wait_and_swap(input int idx, input int bank, input int ps_lo, input int ps_hi);
    int d;
    d = $urandom_range(ps_hi, ps_lo);
    repeat (d) begin
      bus.start      = 1'($urandom_range(1, 0));
      bus.ld_ack     = 1'($urandom_range(1, 0));
      bus.num_layers = LW'($urandom);
      tick();
      check_val("wait_hold_busy", bus.busy, 1);
      check_val("wait_no_req", bus.ld_req, 0);
      check_val("wait_no_ps", bus.pass_start, 0);
    end
    bus.start     = 1'b0;
    bus.ld_ack    = 1'b0;
    bus.pass_done = 1'b1;
    tick();
    bus.pass_done = 1'b0;
    check_val("swap_bank_old", bus.bank_sel, 32'(bank));
    check_val("swap_idx_old", bus.layer_idx, 32'(idx));
    tick();
    check_val("post_swap_bank", bus.bank_sel, 32'(1 - bank));
  endtask

  task automatic run_valid(input int n, input int ack_lo, input int ack_hi, input int ps_lo, input int ps_hi);
    int b_ld, b_clr, b_ps, b_done;
    b_ld = cnt_ld; b_clr = cnt_clr; b_ps = cnt_ps; b_done = cnt_done;
    idx_q.delete();
    do_start(n);
    check_val("start_busy", bus.busy, 1);
    check_val("start_err_clr", bus.err, 0);
    for (int i = 0; i < n; i++) begin
      check_val("layer_req", bus.ld_req, 1);
      check_val("layer_idx", bus.layer_idx, 32'(i));
      check_val("layer_bank", bus.bank_sel, 32'(i % 2));
      load_and_launch(i, ack_lo, ack_hi);
      wait_and_swap(i, i % 2, ps_lo, ps_hi);
    end
    check_val("done_pulse", bus.done, 1);
    check_val("done_busy", bus.busy, 1);
    check_val("done_no_req", bus.ld_req, 0);
    check_val("final_idx", bus.layer_idx, 32'(n - 1));
    check_val("final_bank", bus.bank_sel, 32'(n % 2));
    bus.start      = 1'b1;
    bus.num_layers = LW'(1);
    tick();
    bus.start      = 1'b0;
    check_val("idle_done_low", bus.done, 0);
    check_val("idle_busy_low", bus.busy, 0);
    check_val("start_on_done_ignored", bus.ld_req, 0);
    check_val("idle_hold_idx", bus.layer_idx, 32'(n - 1));
    check_val("cnt_ld_req", 32'(cnt_ld - b_ld), 32'(n));
    check_val("cnt_acc_clr", 32'(cnt_clr - b_clr), 32'(n));
    check_val("cnt_pass_start", 32'(cnt_ps - b_ps), 32'(n));
    check_val("cnt_done", 32'(cnt_done - b_done), 1);
    check_val("idx_q_size", 32'(idx_q.size()), 32'(n));
    for (int i = 0; i < idx_q.size(); i++) check_val("idx_seq", 32'(idx_q[i]), 32'(i));
  endtask

  task automatic run_zero();
    int b_ld;
    b_ld = cnt_ld;
    do_start(0);
    check_val("zero_done", bus.done, 1);
    check_val("zero_busy", bus.busy, 1);
    check_val("zero_err", bus.err, 0);
    tick();
    check_val("zero_done_end", bus.done, 0);
    check_val("zero_busy_end", bus.busy, 0);
    check_val("zero_no_req", 32'(cnt_ld - b_ld), 0);
  endtask

  task automatic run_over(input int n);
    do_start(n);
    check_val("over_err", bus.err, 1);
    check_val("over_busy", bus.busy, 0);
    check_val("over_no_req", bus.ld_req, 0);
    tick();
    check_val("over_err_sticky", bus.err, 1);
    check_val("over_busy_idle", bus.busy, 0);
  endtask

  initial begin
    int n, b_done;
    bus.start = 1'b0; bus.num_layers = '0; bus.ld_ack = 1'b0; bus.pass_done = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_req", bus.ld_req, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_err", bus.err, 0);
    check_val("rst_idx", bus.layer_idx, 0);
    check_val("rst_bank", bus.bank_sel, 0);
    rst = 1'b1;
    tick();

    run_valid(3, 2, 2, 4, 4);
    run_over(9);
    run_zero();

    // reset mid-WAIT of layer 1 (bank_sel and layer_idx both 1)
    do_start(2);
    load_and_launch(0, 0, 2);
    wait_and_swap(0, 0, 0, 3);
    load_and_launch(1, 0, 2);
    b_done = cnt_done;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_req", bus.ld_req, 0);
    check_val("abort_clr", bus.acc_clr, 0);
    check_val("abort_ps", bus.pass_start, 0);
    check_val("abort_done", bus.done, 0);
    check_val("abort_err", bus.err, 0);
    check_val("abort_idx", bus.layer_idx, 0);
    check_val("abort_bank", bus.bank_sel, 0);
    bus.pass_done = 1'b1;
    repeat (3) tick();
    bus.pass_done = 1'b0;
    check_val("abort_no_done", 32'(cnt_done - b_done), 0);
    check_val("abort_idle", bus.busy, 0);

`ifdef NPU_LAYER_SCHED_WATCHDOG_EN
    do_start(1);
    load_and_launch(0, 0, 1);
    repeat (4 * WIDTH - 1) tick();
    check_val("wd_still_wait", bus.busy, 1);
    check_val("wd_no_err_yet", bus.err, 0);
    tick();
    check_val("wd_err", bus.err, 1);
    check_val("wd_idle", bus.busy, 0);
    check_val("wd_no_done", bus.done, 0);
    tick();
    check_val("wd_err_sticky", bus.err, 1);
    do_start(1);
    check_val("wd_err_cleared", bus.err, 0);
    load_and_launch(0, 0, 1);
    repeat (4 * WIDTH - 1) tick();
    bus.pass_done = 1'b1;
    tick();
    bus.pass_done = 1'b0;
    check_val("wd_limit_swap_err", bus.err, 0);
    check_val("wd_limit_swap_busy", bus.busy, 1);
    tick();
    check_val("wd_limit_done", bus.done, 1);
    tick();
`else
    do_start(1);
    load_and_launch(0, 0, 1);
    repeat (200) tick();
    check_val("nowd_still_wait", bus.busy, 1);
    check_val("nowd_no_err", bus.err, 0);
    wait_and_swap(0, 0, 0, 0);
    check_val("nowd_done", bus.done, 1);
    tick();
`endif

    for (int r = 0; r < 14; r++) begin
      n = $urandom_range(10, 0);
      if (n > MAX_LAYERS)  run_over(n);
      else if (n == 0)     run_zero();
      else                 run_valid(n, 0, 4, 0, 8);
      repeat ($urandom_range(2, 0)) tick();
    end
    run_over(15);
    run_valid(MAX_LAYERS, 0, 3, 0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
